// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing defaults, derived totals and tracker state encoding.
// Used by both the sync generator and the sync tracker.
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF     = 640;
    localparam int H_FRONT_PORCH_DEF = 16;
    localparam int H_SYNC_PULSE_DEF  = 96;
    localparam int H_BACK_PORCH_DEF  = 48;
    localparam int V_DISPLAY_DEF     = 480;
    localparam int V_FRONT_PORCH_DEF = 10;
    localparam int V_SYNC_PULSE_DEF  = 2;
    localparam int V_BACK_PORCH_DEF  = 33;

    localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FRONT_PORCH_DEF + H_SYNC_PULSE_DEF + H_BACK_PORCH_DEF;
    localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FRONT_PORCH_DEF + V_SYNC_PULSE_DEF + V_BACK_PORCH_DEF;
    localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_PORCH_DEF;
    localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_PORCH_DEF;

    typedef logic [1:0] track_state_t;

    localparam track_state_t ST_SEARCH = 2'd0;
    localparam track_state_t ST_VERIFY = 2'd1;
    localparam track_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers an active-low sync input once and flags its falling edge.
// The edge pulse is valid the cycle after the input first reads low.
module vga_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic fall
);

    logic sync_q;
    logic sync_qq;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            sync_qq <= 1'b1;
        end else begin
            sync_q  <= sync_in;
            sync_qq <= sync_q;
        end
    end

    assign fall = sync_qq & ~sync_q;

endmodule

// File: rtl/hvsync_tracker.sv
// Recovers pixel/line position from incoming hsync/vsync and qualifies the
// timing against the expected line and frame lengths before declaring lock.
module hvsync_tracker
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY     = H_DISPLAY_DEF,
    parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
    parameter int H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
    parameter int H_BACK_PORCH  = H_BACK_PORCH_DEF,
    parameter int V_DISPLAY     = V_DISPLAY_DEF,
    parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
    parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT_PORCH;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT_PORCH;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_LOAD     = 10'(H_SYNC_START + 1);
    localparam logic [9:0]  V_LOAD     = 10'(V_SYNC_START);
    localparam logic [9:0]  H_DISP_END = 10'(H_DISPLAY);
    localparam logic [9:0]  V_DISP_END = 10'(V_DISPLAY);
    localparam logic [10:0] LINE_GOOD  = 11'(H_TOTAL - 1);
    localparam logic [10:0] LINE_TMO   = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  FRAME_GOOD = 10'(V_TOTAL);

    logic         hs_fall;
    logic         vs_fall;
    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic [10:0]  line_cnt;
    logic [9:0]   frame_cnt;
    logic [9:0]   frame_edges;
    logic         skip_first;
    track_state_t state;
    track_state_t state_nxt;
    logic         err;
    logic         enter_verify;
    logic         line_bad;
    logic         timeout;
    logic         h_wrap;

    vga_sync_edge u_hs_edge (.clk(clk), .rst_n(rst_n), .sync_in(hsync_in), .fall(hs_fall));
    vga_sync_edge u_vs_edge (.clk(clk), .rst_n(rst_n), .sync_in(vsync_in), .fall(vs_fall));

    // line_cnt restarts at 0 on an edge, so a correct line reads H_TOTAL-1 at the next edge.
    assign line_bad     = hs_fall && (line_cnt != LINE_GOOD) && !(state == ST_VERIFY && skip_first);
    assign timeout      = !hs_fall && (line_cnt >= LINE_TMO);
    assign frame_edges  = (hs_fall && frame_cnt != 10'h3FF) ? frame_cnt + 10'd1 : frame_cnt;
    assign enter_verify = (state == ST_SEARCH) && vs_fall;
    assign h_wrap       = !hs_fall && (h_cnt == H_LAST);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_fall) state_nxt = ST_VERIFY;
            end
            ST_VERIFY, ST_LOCKED: begin
                if (line_bad || timeout) begin
                    err       = 1'b1;
                    state_nxt = ST_SEARCH;
                end else if (vs_fall) begin
                    if (frame_edges == FRAME_GOOD) begin
                        state_nxt = ST_LOCKED;
                    end else begin
                        err       = 1'b1;
                        state_nxt = ST_SEARCH;
                    end
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_SEARCH;
            h_cnt      <= '0;
            v_cnt      <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
            skip_first <= 1'b0;
        end else begin
            state <= state_nxt;

            if (hs_fall)     h_cnt <= H_LOAD;
            else if (h_wrap) h_cnt <= '0;
            else             h_cnt <= h_cnt + 10'd1;

            // A vsync edge realigns the line count and overrides the end-of-line increment.
            if (vs_fall)     v_cnt <= V_LOAD;
            else if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

            if (enter_verify || hs_fall) line_cnt <= '0;
            else if (line_cnt != 11'h7FF) line_cnt <= line_cnt + 11'd1;

            if (enter_verify || vs_fall) frame_cnt <= '0;
            else                         frame_cnt <= frame_edges;

            if (enter_verify) skip_first <= 1'b1;
            else if (hs_fall) skip_first <= 1'b0;
        end
    end

    assign hpos        = h_cnt;
    assign vpos        = v_cnt;
    assign locked      = (state == ST_LOCKED);
    assign display_on  = locked && (h_cnt < H_DISP_END) && (v_cnt < V_DISP_END);
    assign frame_start = locked && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign sync_err    = err;

endmodule

// File: tb/tb_hvsync_tracker.sv
// Directed bench for hvsync_tracker using a scaled-down timing (16 x 12 frame)
// driven by a behavioural sync generator with fault-injection knobs.
module tb_hvsync_tracker;

    localparam int HD = 8, HFP = 2, HSP = 3, HBP = 3;
    localparam int VD = 6, VFP = 2, VSP = 2, VBP = 2;
    localparam int HT = HD + HFP + HSP + HBP;
    localparam int VT = VD + VFP + VSP + VBP;
    localparam int HSS = HD + HFP;
    localparam int VSS = VD + VFP;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       locked;
    logic       frame_start;
    logic       sync_err;

    hvsync_tracker #(
        .H_DISPLAY(HD), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_DISPLAY(VD), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int exp_hpos;
        int exp_vpos;
        bit exp_disp;
        bit exp_fs;
    } probe_t;

    probe_t probes[9];

    int gen_h = 0, gen_v = 0;
    bit short_line = 0, short_frame = 0, hold_hs = 0;
    int n_chk = 0, n_pass = 0;
    int err_cnt = 0, fs_cnt = 0, e0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Drive one generator cycle, then read the DUT just after the edge that sampled it.
    // Outputs read here lag the generator by one cycle, so hpos/vpos should equal gen_h/gen_v.
    task automatic tick();
        int h_last;
        int v_last;
        h_last = short_line ? HT - 2 : HT - 1;
        v_last = short_frame ? VT - 2 : VT - 1;
        if (gen_h >= h_last) begin
            gen_h = 0;
            short_line = 0;
            if (gen_v >= v_last) gen_v = 0;
            else gen_v++;
        end else begin
            gen_h++;
        end
        hsync_in = hold_hs || !(gen_h >= HSS && gen_h < HSS + HSP);
        vsync_in = !(gen_v >= VSS && gen_v < VSS + VSP);
        @(posedge clk);
        #1;
        if (sync_err === 1'b1) err_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic wait_for(input int h, input int v, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(gen_h == h && gen_v == v) && n < 4 * FRAME);
        if (!(gen_h == h && gen_v == v)) begin
            n_chk++;
            $display("FAIL %s: position %0d,%0d not reached within %0d cycles", name, h, v, n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_display_on"}, display_on, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_hpos"}, hpos, 0);
        check({tag, "_vpos"}, vpos, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        probes[0] = '{h: 0,  v: 0,  exp_hpos: 0,  exp_vpos: 0,  exp_disp: 1, exp_fs: 1};
        probes[1] = '{h: 7,  v: 0,  exp_hpos: 7,  exp_vpos: 0,  exp_disp: 1, exp_fs: 0};
        probes[2] = '{h: 8,  v: 0,  exp_hpos: 8,  exp_vpos: 0,  exp_disp: 0, exp_fs: 0};
        probes[3] = '{h: 0,  v: 1,  exp_hpos: 0,  exp_vpos: 1,  exp_disp: 1, exp_fs: 0};
        probes[4] = '{h: 3,  v: 5,  exp_hpos: 3,  exp_vpos: 5,  exp_disp: 1, exp_fs: 0};
        probes[5] = '{h: 15, v: 5,  exp_hpos: 15, exp_vpos: 5,  exp_disp: 0, exp_fs: 0};
        probes[6] = '{h: 3,  v: 6,  exp_hpos: 3,  exp_vpos: 6,  exp_disp: 0, exp_fs: 0};
        probes[7] = '{h: 10, v: 8,  exp_hpos: 10, exp_vpos: 8,  exp_disp: 0, exp_fs: 0};
        probes[8] = '{h: 15, v: 11, exp_hpos: 15, exp_vpos: 11, exp_disp: 0, exp_fs: 0};

        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        err_cnt = 0;

        // Acquisition: SEARCH -> VERIFY at the first vsync edge, LOCKED at the second.
        wait_for(0, VSS, "acq_vs1");
        check("acq_vs1_locked", locked, 0);
        tick();
        check("acq_verify_locked", locked, 0);
        wait_for(0, VSS, "acq_vs2");
        check("acq_vs2_locked", locked, 0);
        tick();
        check("acq_lock", locked, 1);
        check("acq_no_err", err_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            wait_for(probes[i].h, probes[i].v, "probe");
            check($sformatf("probe%0d_hpos", i), hpos, probes[i].exp_hpos);
            check($sformatf("probe%0d_vpos", i), vpos, probes[i].exp_vpos);
            check($sformatf("probe%0d_disp", i), display_on, probes[i].exp_disp);
            check($sformatf("probe%0d_fs", i), frame_start, probes[i].exp_fs);
            check($sformatf("probe%0d_err", i), sync_err, 0);
        end

        fs_cnt = 0;
        repeat (2 * FRAME) tick();
        check("fs_per_two_frames", fs_cnt, 2);
        check("steady_no_err", err_cnt, 0);

        // One line of HT-1 clocks.
        wait_for(1, 2, "short_setup");
        short_line = 1;
        e0 = err_cnt;
        wait_for(10, 3, "short_edge");
        check("short_sync_err", sync_err, 1);
        tick();
        check("short_unlock", locked, 0);
        wait_for(0, VSS, "short_vs1");
        tick();
        check("short_verify", locked, 0);
        wait_for(0, VSS, "short_vs2");
        tick();
        check("short_relock", locked, 1);
        check("short_err_count", err_cnt - e0, 1);

        // hsync held high: last edge read at (10,0), timeout 2*HT cycles later at (10,2).
        wait_for(15, 0, "tmo_setup");
        hold_hs = 1;
        e0 = err_cnt;
        wait_for(9, 2, "tmo_pre");
        check("tmo_not_early", err_cnt - e0, 0);
        check("tmo_locked_before", locked, 1);
        tick();
        check("tmo_sync_err", sync_err, 1);
        tick();
        check("tmo_unlock", locked, 0);
        wait_for(3, 3, "tmo_active");
        check("tmo_display_off", display_on, 0);
        wait_for(15, 3, "tmo_release");
        hold_hs = 0;
        wait_for(0, VSS, "tmo_vs1");
        tick();
        check("tmo_verify", locked, 0);
        wait_for(0, VSS, "tmo_vs2");
        tick();
        check("tmo_relock", locked, 1);
        check("tmo_err_count", err_cnt - e0, 1);

        // Frames of VT-1 lines: every measured frame is short, so lock never returns.
        wait_for(1, VSS, "sf_setup");
        short_frame = 1;
        e0 = err_cnt;
        wait_for(0, VSS, "sf_vs1");
        check("sf_sync_err", sync_err, 1);
        tick();
        check("sf_unlock", locked, 0);
        for (int k = 2; k <= 4; k++) begin
            wait_for(0, VSS, "sf_vs");
            tick();
            check($sformatf("sf_vs%0d_locked", k), locked, 0);
        end
        check("sf_err_count", err_cnt - e0, 2);
        short_frame = 0;
        wait_for(0, VSS, "sf_vs5");
        tick();
        check("sf_relock", locked, 1);

        // One-cycle reset in the middle of active video while locked.
        wait_for(3, 4, "rst_setup");
        check("rst_pre_display", display_on, 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        wait_for(0, VSS, "rst_vs1");
        tick();
        check("rst_verify", locked, 0);
        wait_for(0, VSS, "rst_vs2");
        check("rst_vs2_locked", locked, 0);
        tick();
        check("rst_relock", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
